// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART RX back end.
//   state_t   : frame checker FSM encoding
//   PAR_EVEN / PAR_ODD : values of the par_typ configuration bit
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP   = 3'd3,
    ST_REPORT = 3'd4
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_frame_checker_if.sv
// Bus between the RX sampler/control side and the frame checker.
//   master : drives sampled bit, strobes, frame configuration and clear
//   slave  : the checker; returns sticky flags, frame verdict and error count
interface uart_frame_checker_if #(
  parameter int MAX_STOP  = 2,
  parameter int CNT_WIDTH = 8
);
  localparam int STW = $clog2(MAX_STOP + 1);

  logic                 sampled_bit;
  logic                 DONE;
  logic                 frame_start;
  logic                 par_en;
  logic                 par_typ;
  logic [STW-1:0]       stp_cfg;
  logic                 clearFlag;
  logic                 par_err;
  logic                 stp_err;
  logic                 frame_done;
  logic                 frame_ok;
  logic [CNT_WIDTH-1:0] err_cnt;

  modport master (
    output sampled_bit, DONE, frame_start, par_en, par_typ, stp_cfg, clearFlag,
    input  par_err, stp_err, frame_done, frame_ok, err_cnt
  );

  modport slave (
    input  sampled_bit, DONE, frame_start, par_en, par_typ, stp_cfg, clearFlag,
    output par_err, stp_err, frame_done, frame_ok, err_cnt
  );
endinterface

// File: rtl/uart_err_counter.sv
// Saturating event counter with synchronous clear.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (has priority over inc)
//   inc      : count one event
//   cnt      : current count, holds at all-ones
module uart_err_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/uart_frame_checker.sv
// UART RX frame checker: verifies data parity and stop bits of one frame,
// one sampled bit per DONE strobe.
//   CLK, RST : clock, async active-high reset
//   bus      : slave side of uart_frame_checker_if (strobes/config in,
//              sticky flags, frame verdict and error count out)
//
//   state  | meaning
//   IDLE   | waiting for frame_start
//   DATA   | accumulating DATA_WIDTH data bits into parity
//   PARITY | checking the parity bit
//   STOP   | checking stp_cfg stop bits (all must be 1)
//   REPORT | one cycle: frame_done/frame_ok, sticky flag and counter update
module uart_frame_checker
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_STOP   = 2,
  parameter int CNT_WIDTH  = 8
) (
  input logic                  CLK,
  input logic                  RST,
  uart_frame_checker_if.slave  bus
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);
  localparam int STW = $clog2(MAX_STOP + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  state_t         state_q, state_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic [STW-1:0] stp_cnt_q, stp_cnt_d;
  logic [STW-1:0] stp_num_q, stp_num_d;
  logic           par_en_q, par_en_d;
  logic           par_typ_q, par_typ_d;
  logic           acc_q, acc_d;
  logic           lpar_q, lpar_d;
  logic           lstp_q, lstp_d;
  logic           par_err_q, par_err_d;
  logic           stp_err_q, stp_err_d;
  logic [STW-1:0] stp_eff;
  logic           frame_done;
  logic           frame_bad;
  logic           clr;

  // 0 stop bits means 1; anything above MAX_STOP is clamped.
  always_comb begin
    if (bus.stp_cfg == '0)                  stp_eff = STW'(1);
    else if (bus.stp_cfg > STW'(MAX_STOP))  stp_eff = STW'(MAX_STOP);
    else                                    stp_eff = bus.stp_cfg;
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    stp_cnt_d = stp_cnt_q;
    stp_num_d = stp_num_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    acc_d     = acc_q;
    lpar_d    = lpar_q;
    lstp_d    = lstp_q;

    // frame_start restarts from any state and swallows a coincident DONE.
    if (bus.frame_start) begin
      state_d   = ST_DATA;
      bit_cnt_d = '0;
      stp_cnt_d = '0;
      acc_d     = 1'b0;
      lpar_d    = 1'b0;
      lstp_d    = 1'b0;
      par_en_d  = bus.par_en;
      par_typ_d = bus.par_typ;
      stp_num_d = stp_eff;
    end else begin
      case (state_q)
        ST_DATA: if (bus.DONE) begin
          acc_d     = acc_q ^ bus.sampled_bit;
          bit_cnt_d = bit_cnt_q + BCW'(1);
          if (bit_cnt_q == LAST_BIT) state_d = par_en_q ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: if (bus.DONE) begin
          lpar_d  = acc_q ^ bus.sampled_bit ^ par_typ_q;
          state_d = ST_STOP;
        end
        ST_STOP: if (bus.DONE) begin
          if (!bus.sampled_bit) lstp_d = 1'b1;
          stp_cnt_d = stp_cnt_q + STW'(1);
          if (stp_cnt_q == stp_num_q - STW'(1)) state_d = ST_REPORT;
        end
        ST_REPORT: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  assign frame_done = (state_q == ST_REPORT);
  assign frame_bad  = frame_done & (lpar_q | lstp_q);
  assign clr        = ~bus.clearFlag;

  // Clear beats a coincident REPORT: that frame's errors are discarded.
  always_comb begin
    par_err_d = par_err_q | (frame_done & lpar_q);
    stp_err_d = stp_err_q | (frame_done & lstp_q);
    if (clr) begin
      par_err_d = 1'b0;
      stp_err_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      stp_cnt_q <= '0;
      stp_num_q <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      acc_q     <= 1'b0;
      lpar_q    <= 1'b0;
      lstp_q    <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      stp_cnt_q <= stp_cnt_d;
      stp_num_q <= stp_num_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      acc_q     <= acc_d;
      lpar_q    <= lpar_d;
      lstp_q    <= lstp_d;
      par_err_q <= par_err_d;
      stp_err_q <= stp_err_d;
    end
  end

  uart_err_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk (CLK),
    .rst (RST),
    .clr (clr),
    .inc (frame_bad),
    .cnt (bus.err_cnt)
  );

  assign bus.par_err    = par_err_q;
  assign bus.stp_err    = stp_err_q;
  assign bus.frame_done = frame_done;
  assign bus.frame_ok   = frame_done & ~(lpar_q | lstp_q);

endmodule

// File: tb/tb_uart_frame_checker.sv
// Directed testbench for uart_frame_checker (DATA_WIDTH=8, MAX_STOP=2, CNT_WIDTH=8).
module tb_uart_frame_checker;
  import uart_rx_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  int   n_checks = 0;
  int   n_errors = 0;

  uart_frame_checker_if #(.MAX_STOP(2), .CNT_WIDTH(8)) bus ();

  uart_frame_checker #(.DATA_WIDTH(8), .MAX_STOP(2), .CNT_WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_bit(input logic b);
    bus.sampled_bit = b;
    bus.DONE        = 1'b1;
    cycle();
    bus.DONE        = 1'b0;
    bus.sampled_bit = 1'b0;
  endtask

  // Config is scrambled right after frame_start to show it was latched.
  task automatic start_frame(input logic pe, input logic pt, input logic [1:0] sc);
    bus.par_en      = pe;
    bus.par_typ     = pt;
    bus.stp_cfg     = sc;
    bus.frame_start = 1'b1;
    cycle();
    bus.frame_start = 1'b0;
    bus.par_en      = ~pe;
    bus.par_typ     = ~pt;
    bus.stp_cfg     = sc + 2'd1;
  endtask

  task automatic send_data(input logic [7:0] d, input string tag);
    for (int i = 0; i < 8; i++) begin
      do_bit(d[i]);
      if (i == 3) cycle();
    end
    chk({tag, " no early done"}, bus.frame_done, 0);
  endtask

  task automatic send_stops(input logic [3:0] s, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      do_bit(s[i]);
      if (i < n - 1) chk({tag, " stop pending"}, bus.frame_done, 0);
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input logic pe,
                           input logic pt, input logic pbit, input logic [1:0] sc,
                           input logic [3:0] s, input int n, input logic exp_ok,
                           input logic exp_pe, input logic exp_se, input logic [7:0] exp_cnt);
    start_frame(pe, pt, sc);
    send_data(d, tag);
    if (pe) do_bit(pbit);
    send_stops(s, n, tag);
    chk({tag, " frame_done"}, bus.frame_done, 1);
    chk({tag, " frame_ok"}, bus.frame_ok, exp_ok);
    cycle();
    chk({tag, " done pulse"}, bus.frame_done, 0);
    chk({tag, " par_err"}, bus.par_err, exp_pe);
    chk({tag, " stp_err"}, bus.stp_err, exp_se);
    chk({tag, " err_cnt"}, bus.err_cnt, exp_cnt);
  endtask

  initial begin
    RST             = 1'b1;
    bus.sampled_bit = 1'b0;
    bus.DONE        = 1'b0;
    bus.frame_start = 1'b0;
    bus.par_en      = 1'b0;
    bus.par_typ     = 1'b0;
    bus.stp_cfg     = 2'd1;
    bus.clearFlag   = 1'b1;
    repeat (2) cycle();
    chk("reset par_err", bus.par_err, 0);
    chk("reset stp_err", bus.stp_err, 0);
    chk("reset frame_done", bus.frame_done, 0);
    chk("reset frame_ok", bus.frame_ok, 0);
    chk("reset err_cnt", bus.err_cnt, 0);
    RST = 1'b0;
    cycle();

    // tag, data, par_en, par_typ, par_bit, stp_cfg, stops, n, ok, par_err, stp_err, cnt
    run_frame("even_good", 8'h55, 1, PAR_EVEN, 0, 2'd1, 4'b0001, 1, 1, 0, 0, 8'd0);
    run_frame("odd_bad",   8'h01, 1, PAR_ODD,  1, 2'd1, 4'b0001, 1, 0, 1, 0, 8'd1);
    run_frame("odd_good",  8'h01, 1, PAR_ODD,  0, 2'd1, 4'b0001, 1, 1, 1, 0, 8'd1);
    run_frame("stop2_bad", 8'hA5, 0, PAR_EVEN, 0, 2'd2, 4'b0001, 2, 0, 1, 1, 8'd2);
    run_frame("stop2_ok",  8'hA5, 0, PAR_EVEN, 0, 2'd2, 4'b0011, 2, 1, 1, 1, 8'd2);
    run_frame("stp_cfg0",  8'h3C, 1, PAR_EVEN, 0, 2'd0, 4'b0001, 1, 1, 1, 1, 8'd2);
    run_frame("stp_clamp", 8'hFF, 1, PAR_ODD,  1, 2'd3, 4'b0011, 2, 1, 1, 1, 8'd2);

    bus.clearFlag = 1'b0;
    cycle();
    bus.clearFlag = 1'b1;
    chk("clear par_err", bus.par_err, 0);
    chk("clear stp_err", bus.stp_err, 0);
    chk("clear err_cnt", bus.err_cnt, 0);

    for (int i = 1; i <= 255; i++) begin
      run_frame("sat_fill", 8'h00, 0, PAR_EVEN, 0, 2'd1, 4'b0000, 1, 0, 0, 1, 8'(i));
    end
    run_frame("sat_hold", 8'h00, 0, PAR_EVEN, 0, 2'd1, 4'b0000, 1, 0, 0, 1, 8'd255);

    // Clear coincident with REPORT of a frame with both errors.
    start_frame(1, PAR_EVEN, 2'd1);
    send_data(8'h07, "clr_report");
    do_bit(1'b0);
    do_bit(1'b0);
    bus.clearFlag = 1'b0;
    chk("clr_report frame_done", bus.frame_done, 1);
    chk("clr_report frame_ok", bus.frame_ok, 0);
    cycle();
    bus.clearFlag = 1'b1;
    chk("clr_report par_err", bus.par_err, 0);
    chk("clr_report stp_err", bus.stp_err, 0);
    chk("clr_report err_cnt", bus.err_cnt, 0);

    // Abort after 4 data bits; restart with a coincident DONE that must be dropped.
    start_frame(1, PAR_EVEN, 2'd1);
    for (int i = 0; i < 4; i++) do_bit(1'b1);
    chk("abort no done", bus.frame_done, 0);
    bus.par_en      = 1'b1;
    bus.par_typ     = PAR_EVEN;
    bus.stp_cfg     = 2'd1;
    bus.frame_start = 1'b1;
    bus.DONE        = 1'b1;
    bus.sampled_bit = 1'b1;
    cycle();
    bus.frame_start = 1'b0;
    bus.DONE        = 1'b0;
    bus.sampled_bit = 1'b0;
    chk("restart no done", bus.frame_done, 0);
    send_data(8'h0F, "restart");
    do_bit(1'b0);
    send_stops(4'b0001, 1, "restart");
    chk("restart frame_done", bus.frame_done, 1);
    chk("restart frame_ok", bus.frame_ok, 1);
    cycle();
    chk("restart err_cnt", bus.err_cnt, 0);
    chk("restart par_err", bus.par_err, 0);

    // Reset in the middle of STOP.
    run_frame("pre_rst", 8'h01, 1, PAR_EVEN, 0, 2'd1, 4'b0001, 1, 0, 1, 0, 8'd1);
    start_frame(0, PAR_EVEN, 2'd2);
    send_data(8'hFF, "mid_rst");
    do_bit(1'b1);
    #1 RST = 1'b1;
    #1;
    chk("mid_rst par_err", bus.par_err, 0);
    chk("mid_rst err_cnt", bus.err_cnt, 0);
    chk("mid_rst frame_done", bus.frame_done, 0);
    chk("mid_rst frame_ok", bus.frame_ok, 0);
    cycle();
    RST = 1'b0;
    do_bit(1'b1);
    chk("post_rst idle done", bus.frame_done, 0);
    cycle();
    run_frame("post_rst", 8'h55, 1, PAR_EVEN, 0, 2'd1, 4'b0001, 1, 1, 0, 0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
